// File: rtl/axi4_mid_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters.
// Issued bursts are tracked in an in-order FIFO so R beats route back to their owner.
module axi4_mid_read_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned OUT_DEPTH = 8
) (
  input  logic                        ap_clk,
  input  logic                        areset,
  input  logic [NUM_REQ-1:0]          req_arvalid,
  input  logic [NUM_REQ*64-1:0]       req_araddr,
  input  logic [NUM_REQ*8-1:0]        req_arlen,
  output logic [NUM_REQ-1:0]          req_arready,
  output logic [NUM_REQ-1:0]          req_rvalid,
  output logic [511:0]                req_rdata,
  output logic [1:0]                  req_rresp,
  output logic                        req_rlast,
  input  logic [NUM_REQ-1:0]          req_rready,
  output logic                        m_arvalid,
  output logic [63:0]                 m_araddr,
  output logic [7:0]                  m_arlen,
  output logic [2:0]                  m_arsize,
  output logic [1:0]                  m_arburst,
  output logic                        m_arid,
  input  logic                        m_arready,
  input  logic                        m_rvalid,
  input  logic [511:0]                m_rdata,
  input  logic [1:0]                  m_rresp,
  input  logic                        m_rlast,
  output logic                        m_rready,
  output logic [$clog2(OUT_DEPTH):0]  outstanding,
  output logic                        idle
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned CntW = $clog2(OUT_DEPTH) + 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] last_grant_q, last_grant_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [63:0]     araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic [IdxW-1:0] fifo_q [OUT_DEPTH];
  logic [IdxW-1:0] fifo_d [OUT_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            any_req;
  logic [IdxW-1:0] rr_idx;
  int unsigned     cand;
  int unsigned     sel;
  logic            grant_en;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [IdxW-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(OUT_DEPTH));
  assign head       = fifo_q[rd_ptr_q];

  // Rotating priority search starting one past the last granted requester.
  always_comb begin
    any_req = 1'b0;
    rr_idx  = last_grant_q;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant_q) + k) % NUM_REQ;
      if (!any_req && req_arvalid[cand]) begin
        any_req = 1'b1;
        rr_idx  = IdxW'(cand);
      end
    end
  end

  assign grant_en = (state_q == StIdle) && any_req && !fifo_full && !areset;
  assign sel      = 32'(rr_idx);

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_arready[i] = grant_en && (rr_idx == IdxW'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    push         = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_en) begin
          grant_d  = rr_idx;
          araddr_d = req_araddr[64*sel +: 64];
          arlen_d  = req_arlen[8*sel +: 8];
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (m_arready) begin
          push         = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = !fifo_empty && m_rvalid && m_rready && m_rlast;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = grant_q;
      wr_ptr_d = (wr_ptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Beats go only to the owner of the oldest outstanding burst.
  always_comb begin
    req_rvalid = '0;
    m_rready   = 1'b0;
    if (!fifo_empty) begin
      m_rready = req_rready[head];
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        req_rvalid[i] = m_rvalid && (head == IdxW'(i));
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      grant_q      <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Entries are only read while counted, so the storage needs no reset.
  always_ff @(posedge ap_clk) begin
    fifo_q <= fifo_d;
  end

  assign m_arvalid   = (state_q == StIssue);
  assign m_araddr    = araddr_q;
  assign m_arlen     = arlen_q;
  assign m_arsize    = 3'b110;
  assign m_arburst   = 2'b01;
  assign m_arid      = 1'b0;
  assign req_rdata   = m_rdata;
  assign req_rresp   = m_rresp;
  assign req_rlast   = m_rlast;
  assign outstanding = count_q;
  assign idle        = (state_q == StIdle) && fifo_empty;

endmodule

// File: tb/tb_axi4_mid_read_arbiter.sv
// Randomized scoreboard bench: a queue-based model predicts grants, AR contents
// and R routing; a negedge monitor compares every cycle.
module tb_axi4_mid_read_arbiter;
  localparam int NR = 4;
  localparam int OD = 8;
  localparam int CW = $clog2(OD) + 1;

  logic               ap_clk = 1'b0;
  logic               areset = 1'b1;
  logic [NR-1:0]      req_arvalid = '0;
  logic [NR*64-1:0]   req_araddr = '0;
  logic [NR*8-1:0]    req_arlen = '0;
  logic [NR-1:0]      req_arready;
  logic [NR-1:0]      req_rvalid;
  logic [511:0]       req_rdata;
  logic [1:0]         req_rresp;
  logic               req_rlast;
  logic [NR-1:0]      req_rready = '0;
  logic               m_arvalid;
  logic [63:0]        m_araddr;
  logic [7:0]         m_arlen;
  logic [2:0]         m_arsize;
  logic [1:0]         m_arburst;
  logic               m_arid;
  logic               m_arready = 1'b0;
  logic               m_rvalid = 1'b0;
  logic [511:0]       m_rdata = '0;
  logic [1:0]         m_rresp = '0;
  logic               m_rlast = 1'b0;
  logic               m_rready;
  logic [CW-1:0]      outstanding;
  logic               idle;

  axi4_mid_read_arbiter #(.NUM_REQ(NR), .OUT_DEPTH(OD)) dut (
    .ap_clk(ap_clk), .areset(areset),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .req_rresp(req_rresp), .req_rlast(req_rlast), .req_rready(req_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
    .outstanding(outstanding), .idle(idle)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int          g;
    logic [63:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t  ar_exp[$];     // granted, AR not yet accepted by master
  int   ord_q[$];      // requester owning each outstanding burst, oldest first
  int   grant_log[$];
  int   sl_q[$];       // slave-side burst lengths
  int   last_g = NR - 1;
  int   beat = 0;
  int   checks = 0;
  int   failures = 0;
  logic [NR-1:0] acc = '0;
  logic ar_hs = 1'b0;
  logic r_hs = 1'b0;
  logic [7:0] ar_len_seen = '0;
  int   p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0, fix_len = -1;
  bit   r_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge ap_clk) begin : mon
    bit            allow;
    bit            found;
    int            eg;
    int            idx;
    logic [NR-1:0] exp_arr;
    logic [NR-1:0] exp_rv;
    logic          exp_mr;
    ar_t           e;
    acc   = req_arready;
    ar_hs = 1'b0;
    r_hs  = 1'b0;
    if (areset) begin
      ar_exp.delete();
      ord_q.delete();
      last_g = NR - 1;
    end else begin
      allow = (ar_exp.size() == 0) && (|req_arvalid) && (ord_q.size() < OD);
      found = 1'b0;
      eg    = 0;
      for (int k = 1; k <= NR; k++) begin
        idx = (last_g + k) % NR;
        if (!found && req_arvalid[idx]) begin
          found = 1'b1;
          eg    = idx;
        end
      end
      exp_arr = '0;
      if (allow) exp_arr[eg] = 1'b1;
      chk("arready", req_arready, exp_arr);
      chk("m_arvalid", m_arvalid, ar_exp.size() != 0);
      chk("outstanding", outstanding, ord_q.size());
      chk("idle", idle, (ar_exp.size() == 0) && (ord_q.size() == 0));
      if (ar_exp.size() != 0) begin
        chk("m_araddr", m_araddr, ar_exp[0].addr);
        chk("m_arlen", m_arlen, ar_exp[0].len);
        chk("ar_const", {m_arsize, m_arburst, m_arid}, {3'b110, 2'b01, 1'b0});
      end
      exp_rv = '0;
      exp_mr = 1'b0;
      if (ord_q.size() != 0) begin
        exp_rv[ord_q[0]] = m_rvalid;
        exp_mr = req_rready[ord_q[0]];
      end
      chk("req_rvalid", req_rvalid, exp_rv);
      chk("m_rready", m_rready, exp_mr);
      chk("r_mirror", {req_rdata === m_rdata, req_rresp === m_rresp, req_rlast === m_rlast},
          3'b111);
      r_hs = m_rvalid && m_rready;
      if (m_rvalid && exp_mr && m_rlast && ord_q.size() != 0) void'(ord_q.pop_front());
      if (m_arvalid && m_arready && ar_exp.size() != 0) begin
        e = ar_exp.pop_front();
        ord_q.push_back(e.g);
        ar_hs       = 1'b1;
        ar_len_seen = m_arlen;
      end
      for (int i = 0; i < NR; i++) if (req_arready[i]) grant_log.push_back(i);
      if (allow) begin
        ar_exp.push_back('{eg, req_araddr[64*eg +: 64], req_arlen[8*eg +: 8]});
        last_g = eg;
      end
    end
  end

  task automatic drive();
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) req_arvalid[i] = 1'b0;
      if (!req_arvalid[i] && $urandom_range(0, 99) < p_arv) begin
        req_arvalid[i] = 1'b1;
        req_araddr[64*i +: 64] = {$urandom, $urandom};
        req_arlen[8*i +: 8] = (fix_len >= 0) ? 8'(fix_len) : 8'($urandom_range(0, 3));
      end
      req_rready[i] = $urandom_range(0, 99) < p_rr;
    end
    m_arready = $urandom_range(0, 99) < p_arr;
    if (ar_hs) sl_q.push_back(int'(ar_len_seen));
    if (r_hs && sl_q.size() != 0) begin
      if (m_rlast) begin
        void'(sl_q.pop_front());
        beat = 0;
      end else begin
        beat++;
      end
    end
    if (!(m_rvalid && !r_hs)) begin
      m_rvalid = r_en && (sl_q.size() != 0) && ($urandom_range(0, 99) < p_rv);
      m_rlast  = (sl_q.size() != 0) && (beat == sl_q[0]);
      for (int j = 0; j < 16; j++) m_rdata[32*j +: 32] = $urandom;
      m_rresp = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) drive();
  endtask

  // Reset for one cycle with a stray beat presented, then check the clean state.
  task automatic do_reset();
    @(posedge ap_clk);
    #1;
    areset      = 1'b1;
    req_arvalid = '0;
    m_arready   = 1'b0;
    m_rvalid    = 1'b1;
    m_rlast     = 1'b0;
    req_rready  = '1;
    @(posedge ap_clk);
    #1;
    areset = 1'b0;
    sl_q.delete();
    beat = 0;
    @(negedge ap_clk);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_m_rready", m_rready, 1'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_m_arvalid", m_arvalid, 1'b0);
    chk("rst_m_araddr", m_araddr, 64'h0);
    @(posedge ap_clk);
    #1;
    m_rvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    do_reset();

    // All four requesting continuously: grants rotate from requester 0.
    p_arv = 100; p_arr = 100; r_en = 1; p_rv = 100; p_rr = 100; fix_len = 0;
    grant_log.delete();
    run(12);
    for (int i = 0; i < 5; i++) begin
      if (i < grant_log.size()) chk("rr_order", grant_log[i], i % NR);
      else begin
        checks++;
        failures++;
        $display("FAIL rr_order actual=missing required=%0d", i % NR);
      end
    end
    fix_len = -1;

    for (int ph = 0; ph < 10; ph++) begin
      p_arv = $urandom_range(10, 100);
      p_arr = $urandom_range(10, 100);
      p_rv  = $urandom_range(30, 100);
      p_rr  = $urandom_range(10, 100);
      run(200);
    end

    // Fill the order FIFO with no read data returning.
    r_en = 0; p_arv = 100; p_arr = 100;
    run(60);
    @(negedge ap_clk);
    chk("fill_outstanding", outstanding, OD);
    chk("fill_no_grant", req_arready, '0);
    r_en = 1; p_rv = 100; p_rr = 100;
    run(300);

    // Reset in the middle of a four-beat burst.
    fix_len = 3; p_arv = 60; p_arr = 100; p_rv = 100; p_rr = 100;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      drive();
      hit = (sl_q.size() != 0) && (sl_q[0] == 3) && (beat == 2) && m_rvalid;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL midburst_wait actual=timeout required=beat2");
    end
    do_reset();
    fix_len = -1;
    for (int ph = 0; ph < 4; ph++) begin
      p_arv = $urandom_range(20, 100);
      p_arr = $urandom_range(20, 100);
      p_rv  = $urandom_range(30, 100);
      p_rr  = $urandom_range(20, 100);
      run(150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_mid_read_arbiter.md
AXI4_MID_READ_ARBITER -- requirements
Module: axi4_mid_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 Parameter OUT_DEPTH, default 8, max outstanding AR bursts (power of 2).
REQ-003 ap_clk  in  1  sole clock; all logic on rising edge.
REQ-004 areset  in  1  reset, synchronous, active-high.
REQ-005 req_arvalid  in  NUM_REQ  per-requester burst request valid.
REQ-006 req_araddr  in  NUM_REQ*64  per-requester byte address; slice i = bits [64i+63:64i].
REQ-007 req_arlen  in  NUM_REQ*8  per-requester AXI burst length (beats-1).
REQ-008 req_arready  out  NUM_REQ  one-hot accept pulse.
REQ-009 req_rvalid  out  NUM_REQ  one-hot read-beat valid.
REQ-010 req_rdata  out  512  shared read data, driven from m_rdata.
REQ-011 req_rresp / req_rlast  out  2 / 1  shared response and last flag.
REQ-012 req_rready  in  NUM_REQ  per-requester beat ready.
REQ-013 m_arvalid, m_araddr, m_arlen  out  1, 64, 8  master AR channel.
REQ-014 m_arsize, m_arburst, m_arid  out  3, 2, 1  constant 3'b110 (64B), 2'b01 (INCR), 1'b0.
REQ-015 m_arready  in  1  master AR ready.
REQ-016 m_rvalid, m_rdata, m_rresp, m_rlast  in  1, 512, 2, 1  master R channel.
REQ-017 m_rready  out  1  master R ready.
REQ-018 outstanding  out  $clog2(OUT_DEPTH)+1  bursts issued, not yet completed.
REQ-019 idle  out  1  high when FSM in IDLE and outstanding==0.

Function
REQ-020 FSM states IDLE, ISSUE; reset state IDLE.
REQ-021 IDLE: if any req_arvalid and outstanding<OUT_DEPTH, grant round-robin starting at (last_grant+1) mod NUM_REQ, pulse req_arready[g] for that single cycle, register araddr/arlen slice g into m_ar*, go ISSUE.
REQ-022 IDLE with order FIFO full: no req_arready asserted; requests wait.
REQ-023 ISSUE: m_arvalid=1, m_araddr/m_arlen stable; on m_arready push g into order FIFO, last_grant<=g, go IDLE next cycle.
REQ-024 m_arvalid SHALL be 0 in IDLE; at most one AR accepted per 2 cycles.
REQ-025 Order FIFO depth OUT_DEPTH, width $clog2(NUM_REQ); read/write pointers wrap modulo OUT_DEPTH; outstanding = count.
REQ-026 R routing (combinational) with FIFO non-empty, head h: req_rvalid[h]=m_rvalid, other bits 0; m_rready=req_rready[h].
REQ-027 FIFO empty: req_rvalid=0, m_rready=0.
REQ-028 Pop on m_rvalid & m_rready & m_rlast; beats are delivered in AR issue order.
REQ-029 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-030 Push when full impossible by REQ-022; pop when empty impossible by REQ-027.
REQ-031 req_rdata/req_rresp/req_rlast SHALL mirror m_rdata/m_rresp/m_rlast unconditionally.
REQ-032 Grant fairness: a continuously requesting requester SHALL be granted within NUM_REQ grants.

Reset
REQ-033 On areset high at a clock edge: FSM=IDLE, m_arvalid=0, m_araddr=0, m_arlen=0, req_arready=0, FIFO pointers and count=0, last_grant=NUM_REQ-1 (first grant to requester 0).
REQ-034 Reset mid-burst discards all outstanding tracking; remaining R beats are not routed (m_rready=0) until a new AR is issued.
REQ-035 idle=1 in the cycle following reset release.

Verification
REQ-036 Reset, then req_arvalid=4'b1111 held -> grants in order 0,1,2,3,0; each req_arready a 1-cycle pulse.
REQ-037 Req 2 asks addr 0x1000 len 3, m_arready=1 -> m_araddr=0x1000, m_arlen=3, m_arsize=3'b110; 4 R beats appear on req_rvalid[2] only, outstanding 1->0 after rlast.
REQ-038 m_arready=0 for 10 cycles in ISSUE -> m_arvalid and m_araddr held; no new req_arready.
REQ-039 Issue OUT_DEPTH=8 bursts, no R beats -> outstanding=8, req_arready stays 0; one rlast -> next grant within 2 cycles.
REQ-040 Interleave bursts to req 1 then req 3, req_rready[1]=0 for 5 cycles -> m_rready=0, req 3 receives nothing until req 1 rlast.
REQ-041 Assert areset during beat 2 of a 4-beat burst -> next cycle outstanding=0, m_rready=0, idle=1.
